// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch controller.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int          PC_STEP_DEF  = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buffer.sv
// One-entry valid/ready output register presenting fetched words to decode.
module fetch_out_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            id_ready,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  // Flush beats load beats drain; contents hold while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= load_instr;
      pc_q    <= load_pc;
    end else if (id_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_pc    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// and handles EX redirects by flushing the output buffer and dropping stale data.
//
// state  | meaning
// S_REQ  | ready to issue a request at pc_q
// S_WAIT | request granted, waiting for rvalid of the fetch at pc_q
// S_DROP | a redirect orphaned the in-flight fetch; swallow its rvalid
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_aligned;
  logic            buf_free;
  logic            buf_load;

  // A request is only issued when the buffer is guaranteed to have room for its response.
  always_comb begin
    buf_free         = !if_valid || id_ready;
    imem_req         = (state_q == S_REQ) && fetch_en && buf_free && !redirect_valid && !rst;
    pc_inc           = pc_q + XLEN'(PC_STEP);
    redirect_aligned = redirect_pc & ~(XLEN'(3));
    buf_load         = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
  end

  assign imem_addr = pc_q;

  // Fetch FSM and PC next-value selection; redirect overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_aligned;
      case (state_q)
        S_WAIT:  state_q <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_q <= imem_rvalid ? S_REQ : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req && imem_gnt) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_q    <= pc_inc;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  fetch_out_buffer #(
    .XLEN(XLEN)
  ) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .flush     (redirect_valid),
    .id_ready  (id_ready),
    .load_instr(imem_rdata),
    .load_pc   (pc_q),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; the bench plays the instruction memory by hand.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] t1_data [3] = '{32'h0000_0013, 32'h0040_0093, 32'h0080_0113};

  fetch_controller dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    rst = 1'b0; imem_gnt = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_req%0d: got %b want 1", i, imem_req); end
      checks++; if (imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
      if (i > 0) begin
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stream_valid%0d: got %b want 1", i, if_valid); end
        checks++; if (if_pc !== 32'(4 * (i - 1))) begin failures++; $display("FAIL stream_pc%0d: got %h want %h", i, if_pc, 32'(4 * (i - 1))); end
        checks++; if (if_instr !== t1_data[i-1]) begin failures++; $display("FAIL stream_instr%0d: got %h want %h", i, if_instr, t1_data[i-1]); end
      end
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = t1_data[i]; #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stream_waitreq%0d: got %b want 0", i, imem_req); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stream_gap%0d: got %b want 0", i, if_valid); end
      step();
      imem_rvalid = 1'b0; imem_rdata = '0; imem_gnt = (i < 2); #1;
    end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stream_last_valid: got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL stream_last_pc: got %h want 8", if_pc); end
    checks++; if (if_instr !== t1_data[2]) begin failures++; $display("FAIL stream_last_instr: got %h want %h", if_instr, t1_data[2]); end
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL stream_next_addr: got %h want c", imem_addr); end
  endtask

  task automatic test_decode_stall();
    id_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req%0d: got %b want 0", k, imem_req); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== t1_data[2]) begin
        failures++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h want v=1 pc=8 instr=%h", k, if_valid, if_pc, if_instr, t1_data[2]);
      end
      step();
    end
    id_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stall_release_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL stall_release_addr: got %h want c", imem_addr); end
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00C0_0193; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stall_drain: got %b want 0", if_valid); end
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'h00C0_0193) begin
      failures++; $display("FAIL stall_next: got v=%b pc=%h instr=%h want v=1 pc=c instr=00c00193", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL rdw_req: got req=%b addr=%h want req=1 addr=10", imem_req, imem_addr); end
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdw_redirect_req: got %b want 0", imem_req); end
    step();
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL rdw_drop1: got req=%b v=%b addr=%h want req=0 v=0 addr=100", imem_req, if_valid, imem_addr);
    end
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdw_drop2_req: got %b want 0", imem_req); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdw_drop3_req: got %b want 0", imem_req); end
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rdw_dropped_valid: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rdw_new_req: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0113; step();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h0000_0113) begin
      failures++; $display("FAIL rdw_target: got v=%b pc=%h instr=%h want v=1 pc=100 instr=00000113", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin failures++; $display("FAIL rdv_req: got req=%b addr=%h want req=1 addr=104", imem_req, imem_addr); end
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD; redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
    step();
    imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rdv_discard: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rdv_no_drop: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0220_0213; step();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h0220_0213) begin
      failures++; $display("FAIL rdv_target: got v=%b pc=%h instr=%h want v=1 pc=200 instr=02200213", if_valid, if_pc, if_instr);
    end
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdv_stall_req: got %b want 0", imem_req); end
    step();
    redirect_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rdv_flush: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL rdv_flush_req: got req=%b addr=%h want req=1 addr=300", imem_req, imem_addr); end
    id_ready = 1'b1; #1;
  endtask

  task automatic test_gnt_hold_fetch_en();
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
        failures++; $display("FAIL hold%0d: got req=%b addr=%h want req=1 addr=300", k, imem_req, imem_addr);
      end
      step();
    end
    imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL hold_gnt: got req=%b addr=%h want req=1 addr=300", imem_req, imem_addr); end
    step();
    imem_gnt = 1'b0; fetch_en = 1'b0; #1;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0330_0313; step();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'h0330_0313) begin
      failures++; $display("FAIL fen_deliver: got v=%b pc=%h instr=%h want v=1 pc=300 instr=03300313", if_valid, if_pc, if_instr);
    end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fen_req_off0: got %b want 0", imem_req); end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL fen_idle%0d: got req=%b v=%b want req=0 v=0", k, imem_req, if_valid); end
    end
    fetch_en = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin failures++; $display("FAIL fen_resume: got req=%b addr=%h want req=1 addr=304", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    step();
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0440_0413; step();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h0440_0413) begin
      failures++; $display("FAIL wrap_deliver: got v=%b pc=%h instr=%h want v=1 pc=fffffffc instr=04400413", if_valid, if_pc, if_instr);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstwait_req: got %b want 0", imem_req); end
    step();
    rst = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL rstwait_state: got v=%b addr=%h want v=0 addr=0", if_valid, imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rstwait_req_after: got %b want 1", imem_req); end
    imem_gnt = 1'b1; step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0550_0513; step();
    imem_rvalid = 1'b0; id_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4 || imem_req !== 1'b0) begin
      failures++; $display("FAIL rstfull_pre: got v=%b pc=%h addr=%h req=%b want v=1 pc=0 addr=4 req=0", if_valid, if_pc, imem_addr, imem_req);
    end
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      failures++; $display("FAIL rstfull_buf: got v=%b instr=%h pc=%h want v=0 instr=0 pc=0", if_valid, if_instr, if_pc);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rstfull_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    id_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_gnt_hold_fetch_en();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
